// File: rtl/serial_add_sub16.sv
// Bit-serial adder/subtractor: one full_adder cell plus a carry flip-flop,
// one bit per clock LSB first, with carry, signed-overflow and zero flags.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_add_sub16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg;
    logic [WIDTH-1:0]   opa_reg, opb_reg, result_reg;
    logic               carry_reg;
    logic               carry_out_reg, overflow_reg, zero_reg;

    logic               fa_sum, fa_carry;
    logic [WIDTH-1:0]   result_next;
    logic               last_step;

    full_adder u_fa (
        .a    (opa_reg[0]),
        .b    (opb_reg[0]),
        .cin  (carry_reg),
        .sum  (fa_sum),
        .cout (fa_carry)
    );

    // Sum bits enter at the MSB so after WIDTH steps bit 0 sits at the LSB.
    assign result_next = {fa_sum, result_reg[WIDTH-1:1]};
    assign last_step   = (cnt_reg == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_step) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg       <= '0;
            opa_reg       <= '0;
            opb_reg       <= '0;
            carry_reg     <= 1'b0;
            result_reg    <= '0;
            carry_out_reg <= 1'b0;
            overflow_reg  <= 1'b0;
            zero_reg      <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        // Subtraction is A + ~B + 1: invert B and seed the carry.
                        opa_reg   <= a;
                        opb_reg   <= sub ? ~b : b;
                        carry_reg <= sub;
                        cnt_reg   <= '0;
                    end
                end
                RUN: begin
                    result_reg <= result_next;
                    opa_reg    <= opa_reg >> 1;
                    opb_reg    <= opb_reg >> 1;
                    carry_reg  <= fa_carry;
                    cnt_reg    <= cnt_reg + 1'b1;
                    if (last_step) begin
                        carry_out_reg <= fa_carry;
                        overflow_reg  <= carry_reg ^ fa_carry;
                        zero_reg      <= (result_next == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state_reg != IDLE);
    assign done      = (state_reg == DONE);
    assign result    = result_reg;
    assign carry_out = carry_out_reg;
    assign overflow  = overflow_reg;
    assign zero      = zero_reg;

endmodule

// File: tb/tb_serial_add_sub16.sv
// Bench for serial_add_sub16: directed vector table, busy/reset corner
// sequences and randomized back-to-back operations against an arithmetic model.

module tb_serial_add_sub16;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic        sub;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        carry_out;
    logic        overflow;
    logic        zero;

    int checks   = 0;
    int failures = 0;

    serial_add_sub16 #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .sub       (sub),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [15:0] va;
        logic [15:0] vb;
        logic        vsub;
        logic [15:0] er;
        logic        eco;
        logic        eov;
        logic        ez;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain modulo-2^16 arithmetic with signed-overflow rules.
    task automatic model(input logic [15:0] ma, mb, input logic msub,
                         output logic [15:0] r, output logic co, ov, z);
        logic [16:0] full;
        if (msub) begin
            full = {1'b0, ma} - {1'b0, mb};
            co   = (ma >= mb);
            r    = full[15:0];
            ov   = (ma[15] != mb[15]) && (r[15] != ma[15]);
        end else begin
            full = {1'b0, ma} + {1'b0, mb};
            co   = full[16];
            r    = full[15:0];
            ov   = (ma[15] == mb[15]) && (r[15] != ma[15]);
        end
        z = (r == 16'h0000);
    endtask

    // mode 0: quiet inputs; 1: scramble a/b/sub/start every cycle;
    // 2: pulse start with other operands at RUN cycle 5 and in DONE.
    task automatic run_op(input logic [15:0] ta, tb, input logic tsub, input int mode,
                          output logic [15:0] r, output logic co, ov, z);
        int lat;
        lat   = 0;
        a     = ta;
        b     = tb;
        sub   = tsub;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            if (mode == 1) begin
                a     = 16'($urandom);
                b     = 16'($urandom);
                sub   = 1'($urandom);
                start = 1'($urandom);
            end else if (mode == 2) begin
                a     = ~ta;
                b     = ~tb;
                sub   = ~tsub;
                start = (k == 5);
            end
            @(posedge clk); #1;
            if (done) lat = k;
        end
        check("done_latency", 32'(lat), 32'd16);
        r  = result;
        co = carry_out;
        ov = overflow;
        z  = zero;
        if (mode == 2) start = 1'b1;
        else if (mode == 1) start = 1'($urandom);
        @(posedge clk); #1;
        start = 1'b0;
        check("done_one_cycle", 32'(done), 32'd0);
        check("busy_fall", 32'(busy), 32'd0);
        check("result_held", 32'(result), 32'(r));
        $display("op a=%04h b=%04h sub=%0d -> result=%04h co=%0d ov=%0d z=%0d",
                 ta, tb, tsub, r, co, ov, z);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_result"}, 32'(result), 32'h0);
        check({tag, "_carry"}, 32'(carry_out), 32'd0);
        check({tag, "_ovf"}, 32'(overflow), 32'd0);
        check({tag, "_zero"}, 32'(zero), 32'd1);
    endtask

    vec_t vecs[8];

    initial begin
        logic [15:0] r, er;
        logic        co, ov, z, eco, eov, ez;
        int          done_cnt;

        vecs[0] = '{16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
        vecs[7] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0};

        rst_n = 1'b0;
        start = 1'b0;
        sub   = 1'b0;
        a     = 16'h0;
        b     = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            run_op(vecs[i].va, vecs[i].vb, vecs[i].vsub, 0, r, co, ov, z);
            check("vec_result", 32'(r), 32'(vecs[i].er));
            check("vec_carry", 32'(co), 32'(vecs[i].eco));
            check("vec_ovf", 32'(ov), 32'(vecs[i].eov));
            check("vec_zero", 32'(z), 32'(vecs[i].ez));
        end

        // Start pulses while busy must not disturb the operation or queue another.
        run_op(16'h0102, 16'h0304, 1'b0, 2, r, co, ov, z);
        check("busy_start_result", 32'(r), 32'h0406);
        done_cnt = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done || busy) done_cnt++;
        end
        check("no_second_done", 32'(done_cnt), 32'd0);

        // Asynchronous reset in the middle of RUN.
        a     = 16'hA5A5;
        b     = 16'h1111;
        sub   = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrun_reset");
        @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done || busy) done_cnt++;
        end
        check("no_done_after_reset", 32'(done_cnt), 32'd0);
        run_op(16'h1234, 16'h4321, 1'b0, 0, r, co, ov, z);
        check("post_reset_result", 32'(r), 32'h5555);

        // Randomized back-to-back operations with inputs scrambled during RUN.
        for (int n = 0; n < 200; n++) begin
            logic [15:0] ra, rb;
            logic        rs;
            ra = 16'($urandom);
            rb = 16'($urandom);
            rs = 1'($urandom);
            if (n % 25 == 0) rb = ra;
            model(ra, rb, rs, er, eco, eov, ez);
            run_op(ra, rb, rs, 1, r, co, ov, z);
            check("rand_result", 32'(r), 32'(er));
            check("rand_carry", 32'(co), 32'(eco));
            check("rand_ovf", 32'(ov), 32'(eov));
            check("rand_zero", 32'(z), 32'(ez));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
